// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, edge-trained update.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_branch,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(32'd4);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [PC_W-1:0]    target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             upd_en_s;
  logic             alias_inv_s;
  logic             eff_taken_s;
  logic [1:0]       ctr_next_s;

  // Fetch-side lookup against the current table contents
  always_comb begin
    lk_idx_s   = if_pc[IDX_W+1:2];
    lk_tag_s   = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    pred_taken = lk_hit_s && ctr_r[lk_idx_s][1];
    if (pred_taken) begin
      pred_target = target_r[lk_idx_s];
    end else begin
      pred_target = if_pc + PC_STEP;
    end
  end

  // Resolution side: mispredict detection, redirect address and counter step
  always_comb begin
    up_idx_s    = upd_pc[IDX_W+1:2];
    up_tag_s    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    up_hit_s    = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    upd_en_s    = upd_valid && upd_is_branch;
    alias_inv_s = upd_valid && !upd_is_branch && upd_pred_taken;
    eff_taken_s = upd_is_branch && upd_taken;
    mispredict  = upd_valid && ((upd_pred_taken != eff_taken_s) ||
                                (eff_taken_s && (upd_pred_target != upd_target)));
    if (eff_taken_s) begin
      redirect_pc = upd_target;
    end else begin
      redirect_pc = upd_pc + PC_STEP;
    end
    if (upd_taken) begin
      if (ctr_r[up_idx_s] == 2'b11) begin
        ctr_next_s = 2'b11;
      end else begin
        ctr_next_s = ctr_r[up_idx_s] + 2'b01;
      end
    end else begin
      if (ctr_r[up_idx_s] == 2'b00) begin
        ctr_next_s = 2'b00;
      end else begin
        ctr_next_s = ctr_r[up_idx_s] - 2'b01;
      end
    end
  end

  // Table storage; flush is applied last so it overrides any valid bit written this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= 2'b01;
      end
    end else begin
      if (upd_en_s) begin
        if (up_hit_s) begin
          ctr_r[up_idx_s] <= ctr_next_s;
          if (upd_taken) begin
            target_r[up_idx_s] <= upd_target;
          end
        end else if (upd_taken) begin
          valid_r[up_idx_s]  <= 1'b1;
          tag_r[up_idx_s]    <= up_tag_s;
          target_r[up_idx_s] <= upd_target;
          ctr_r[up_idx_s]    <= 2'b10;
        end
      end else if (alias_inv_s) begin
        valid_r[up_idx_s] <= 1'b0;
      end
      if (flush) begin
        valid_r <= '0;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_r;
  logic [31:0] mispred_r;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_r <= 32'd0;
      mispred_r  <= 32'd0;
    end else begin
      if (upd_en_s && (branches_r != 32'hFFFF_FFFF)) begin
        branches_r <= branches_r + 32'd1;
      end
      if (mispredict && (mispred_r != 32'hFFFF_FFFF)) begin
        mispred_r <= mispred_r + 32'd1;
      end
    end
  end

  assign stat_branches = branches_r;
  assign stat_mispred  = mispred_r;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined MIPS core. It replaces static predict-not-taken, where every taken branch or jump flushes IF/ID at EX/MEM. The block holds a direct-mapped branch target buffer with 2-bit saturating counters. It is looked up combinationally with the IF-stage PC and trained from the EX/MEM-stage resolved outcome. It also reports mispredictions and the corrective fetch address to the PC mux.

## Interface
Parameters:
- PC_W, 32, width of byte addresses
- IDX_W, 4, index bits; table holds 2^IDX_W entries
- TAG_W, 8, stored tag bits; IDX_W+TAG_W+2 <= PC_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears table state and statistics
- flush  in  1  synchronous; invalidates every entry at the next edge
- if_pc  in  PC_W  fetch address, byte-aligned to word
- pred_taken  out  1  predicted taken for if_pc
- pred_target  out  PC_W  predicted next fetch address
- upd_valid  in  1  a resolved instruction is present in EX/MEM
- upd_is_branch  in  1  resolved instruction is a branch or jump
- upd_pc  in  PC_W  address of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual taken target
- upd_pred_taken  in  1  prediction made at fetch, carried down the pipe
- upd_pred_target  in  PC_W  predicted address, carried down the pipe
- mispredict  out  1  fetch path was wrong; flush IF/ID and ID/EX
- redirect_pc  out  PC_W  correct next fetch address
- stat_branches  out  32  resolved branch count
- stat_mispred  out  32  mispredict count

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, target and a 2-bit counter.
- Lookup:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? stored target : if_pc+4.
  - Additions wrap modulo 2^PC_W.
- Update occurs at the clock edge when upd_valid & upd_is_branch.
- Update on hit:
  - Counter increments on taken, saturating at 11; decrements on not-taken, saturating at 00.
  - Target is overwritten with upd_target when taken.
- Update on miss:
  - Taken: allocate the entry (valid=1, new tag, target, ctr=10), evicting any prior occupant.
  - Not-taken: no change.
- When upd_valid & !upd_is_branch & upd_pred_taken (alias hit on a non-branch), the entry at upd_pc's index is invalidated.
- mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)).
  - For non-branches, upd_taken is treated as 0.
- redirect_pc = (upd_is_branch & upd_taken) ? upd_target : upd_pc+4.
- flush and update in the same cycle: flush wins for valid bits. Counters and targets keep whatever the update writes, but all entries read invalid.

## Timing
- Lookup outputs and mispredict/redirect_pc are combinational: zero latency, same cycle.
- A table write becomes visible to lookup in the cycle after its edge.
- A lookup of the same index in the update cycle returns the old contents.
- Reset values:
  - all valid=0; all counters=01 (weak not-taken); targets and tags 0; statistics 0.
  - pred_taken=0 and pred_target=if_pc+4 during and after reset.
  - mispredict depends only on inputs.
- Reset asserted mid-update: no write occurs, and state is cleared immediately without waiting for a clock.
- Flush takes effect at the next edge and does not clear statistics.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each edge with upd_valid & upd_is_branch.
  - stat_mispred increments on each edge with mispredict.
  - Both saturate at 32'hFFFFFFFF and are cleared only by reset.
- BP_STATS_EN undefined: counter registers are not built and both outputs are constant 0.

## Test plan
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0x44.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle, lookup 0x40 -> pred_taken=1, pred_target=0x100.
- From that state, two taken then two not-taken updates at 0x40 -> counter 11,11,10,01. Lookup predicts taken after the third update and not-taken after the fourth.
- With 0x40 allocated (IDX_W=4, TAG_W=8), lookup 0x80 (same index, tag 2 vs 1) -> miss, pred_target=0x84. Taken update at 0x80 evicts 0x40, so lookup 0x40 then misses.
- Same-cycle update-allocate and lookup of 0x40 -> old (miss) result that cycle, hit the next. flush -> all lookups miss next cycle. Reset pulse between edges during an update -> entry not written.
- With BP_STATS_EN: 10 branch updates including 3 mispredicts -> stat_branches=10, stat_mispred=3. Without the macro -> both 0.
